// File: rtl/efpga_readback_pkg.sv
// Shared types and constants for the eFPGA readback return-path serializer.
package efpga_readback_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;

  typedef logic [1:0] byte_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    CSUM = 2'd2
  } rb_state_e;

  localparam byte_idx_t LAST_BYTE = byte_idx_t'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/efpga_readback_fifo.sv
// Single-clock word FIFO with registered count/full/empty and synchronous reset and flush.
module efpga_readback_fifo #(
  parameter int unsigned Depth = 16,
  parameter int unsigned Width = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic [Width-1:0]           push_data,
  input  logic                       pop,
  output logic [Width-1:0]           head,
  output logic [$clog2(Depth):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  // Full is the registered flag, so a same-cycle pop never makes room for a push.
  assign do_push = push && !full_q;
  assign do_pop  = pop && !empty_q;
  assign count_d = count_q + CntW'(do_push) - CntW'(do_pop);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == CntW'(Depth));
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  assign head  = mem[rd_ptr_q];
  assign count = count_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/efpga_readback_tx.sv
// Readback word FIFO plus MSB-first byte serializer onto the CDC IN valid/ready channel.
// Optional per-frame XOR checksum byte is built when EFPGA_READBACK_CHECKSUM_EN is defined.
module efpga_readback_tx
  import efpga_readback_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned FRAME_WORDS = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] word_data_i,
  input  logic        word_strobe_i,
  input  logic        flush_i,
  output logic [7:0]  in_data_o,
  output logic        in_valid_o,
  input  logic        in_ready_i,
  output logic        overflow_o,
  output logic        busy_o
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end
  if (FRAME_WORDS < 1 || FRAME_WORDS > 255) begin : g_bad_frame
    $error("FRAME_WORDS must be in 1..255");
  end

  rb_state_e       state_q, state_d;
  logic [31:0]     shift_q, shift_d;
  byte_idx_t       idx_q, idx_d;
  logic            valid_q, valid_d;
  logic            overflow_q, overflow_d;
  logic            busy_q, busy_d;
  logic            xfer, load, pop;

  logic            fifo_push, fifo_full, fifo_empty;
  logic [31:0]     fifo_head;
  logic [CntW-1:0] fifo_count;

`ifdef EFPGA_READBACK_CHECKSUM_EN
  localparam logic [7:0] FRAME_LAST = 8'(FRAME_WORDS);
  logic [7:0] csum_q, csum_d;
  logic [7:0] frame_q, frame_d;
`endif

  // A flush in the same cycle discards the strobed word without flagging overflow.
  assign fifo_push = word_strobe_i && !fifo_full && !flush_i;

  efpga_readback_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (32)
  ) u_fifo (
    .clk       (clk_i),
    .reset     (reset_i),
    .flush     (flush_i),
    .push      (fifo_push),
    .push_data (word_data_i),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign xfer = valid_q && in_ready_i;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    load    = 1'b0;
    pop     = 1'b0;
`ifdef EFPGA_READBACK_CHECKSUM_EN
    csum_d  = csum_q;
    frame_d = frame_q;
`endif

    unique case (state_q)
      IDLE: load = !fifo_empty;
      SEND: begin
        if (xfer) begin
          shift_d = {shift_q[23:0], 8'h00};
          idx_d   = idx_q + 2'd1;
`ifdef EFPGA_READBACK_CHECKSUM_EN
          csum_d  = csum_q ^ shift_q[31:24];
`endif
          if (idx_q == LAST_BYTE) begin
`ifdef EFPGA_READBACK_CHECKSUM_EN
            frame_d = frame_q + 8'd1;
            if (frame_d == FRAME_LAST) state_d = CSUM;
            else
`endif
            if (!fifo_empty) load = 1'b1;
            else begin
              valid_d = 1'b0;
              state_d = IDLE;
            end
          end
        end
      end
`ifdef EFPGA_READBACK_CHECKSUM_EN
      CSUM: begin
        if (xfer) begin
          csum_d  = '0;
          frame_d = '0;
          if (!fifo_empty) load = 1'b1;
          else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // Popping on the same edge as the last transfer keeps the stream bubble-free.
    if (load) begin
      pop     = 1'b1;
      shift_d = fifo_head;
      idx_d   = '0;
      valid_d = 1'b1;
      state_d = SEND;
    end

    if (flush_i) begin
      state_d = IDLE;
      shift_d = '0;
      idx_d   = '0;
      valid_d = 1'b0;
      pop     = 1'b0;
`ifdef EFPGA_READBACK_CHECKSUM_EN
      csum_d  = '0;
      frame_d = '0;
`endif
    end
  end

  always_comb begin
    overflow_d = overflow_q || (word_strobe_i && fifo_full);
    // Next-cycle view: something in flight, being pushed, or left in the FIFO after the pop.
    busy_d     = valid_d || fifo_push || (fifo_count != CntW'(pop));
    if (flush_i) begin
      overflow_d = 1'b0;
      busy_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
    end
  end

`ifdef EFPGA_READBACK_CHECKSUM_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      csum_q  <= '0;
      frame_q <= '0;
    end else begin
      csum_q  <= csum_d;
      frame_q <= frame_d;
    end
  end

  assign in_data_o = !valid_q ? 8'h00 : (state_q == CSUM) ? csum_q : shift_q[31:24];
`else
  assign in_data_o = valid_q ? shift_q[31:24] : 8'h00;
`endif

  assign in_valid_o = valid_q;
  assign overflow_o = overflow_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_efpga_readback_tx.sv
// Bench for efpga_readback_tx: byte-stream reference model with random words and ready.
module tb_efpga_readback_tx;

  localparam int unsigned FifoDepth  = 16;
  localparam int unsigned FrameWords = 2;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [31:0] word_data_i;
  logic        word_strobe_i;
  logic        flush_i;
  logic [7:0]  in_data_o;
  logic        in_valid_o;
  logic        in_ready_i;
  logic        overflow_o;
  logic        busy_o;

  always #5 clk = ~clk;

  efpga_readback_tx #(
    .FIFO_DEPTH  (FifoDepth),
    .FRAME_WORDS (FrameWords)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .word_data_i   (word_data_i),
    .word_strobe_i (word_strobe_i),
    .flush_i       (flush_i),
    .in_data_o     (in_data_o),
    .in_valid_o    (in_valid_o),
    .in_ready_i    (in_ready_i),
    .overflow_o    (overflow_o),
    .busy_o        (busy_o)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  int         n_bytes = 0;
  logic [7:0] exp_q [$];
  int         m_words = 0;
`ifdef EFPGA_READBACK_CHECKSUM_EN
  logic [7:0] m_xor = '0;
`endif
  logic       hold_prev = 1'b0;
  logic [7:0] data_prev = '0;
  logic       rand_mode = 1'b0;
  logic       ready_force = 1'b0;
  logic       rand_bit = 1'b0;

  assign in_ready_i = rand_mode ? rand_bit : ready_force;

  always @(posedge clk) begin
    #1 rand_bit = 1'($urandom_range(0, 1));
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected stream: four bytes per word MSB first, plus XOR byte closing each frame.
  task automatic add_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) begin
      exp_q.push_back(w[8*b +: 8]);
`ifdef EFPGA_READBACK_CHECKSUM_EN
      m_xor = m_xor ^ w[8*b +: 8];
`endif
    end
    m_words++;
`ifdef EFPGA_READBACK_CHECKSUM_EN
    if (m_words == int'(FrameWords)) begin
      exp_q.push_back(m_xor);
      m_xor   = '0;
      m_words = 0;
    end
`endif
  endtask

  task automatic send_word(input logic [31:0] w);
    word_data_i   = w;
    word_strobe_i = 1'b1;
    add_word(w);
    @(posedge clk); #1;
    word_strobe_i = 1'b0;
  endtask

  task automatic pulse_flush();
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    int cyc = 0;
    while ((exp_q.size() != 0 || in_valid_o) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_drained"}, 32'(cyc < 3000), 32'd1);
    check({tag, "_busy_low"}, 32'(busy_o), 32'd0);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (reset_i || flush_i) begin
      exp_q.delete();
      m_words = 0;
`ifdef EFPGA_READBACK_CHECKSUM_EN
      m_xor = '0;
`endif
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) check("hold_stable", 32'({in_valid_o, in_data_o}), 32'({1'b1, data_prev}));
      if (in_valid_o && in_ready_i) begin
        n_bytes++;
        check("byte_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("byte_value", 32'(in_data_o), 32'(exp_q.pop_front()));
      end
      hold_prev = in_valid_o && !in_ready_i;
      data_prev = in_data_o;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] db_bytes [4];
    int n_burst;
    int b0;
    int exp_ovf_bytes;
    db_bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

    word_data_i   = '0;
    word_strobe_i = 1'b0;
    flush_i       = 1'b0;
    reset_i       = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;
    @(negedge clk);
    check("rst_data", 32'(in_data_o), 32'd0);
    check("rst_valid", 32'(in_valid_o), 32'd0);
    check("rst_overflow", 32'(overflow_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    @(posedge clk); #1;

    // Single word latency and byte order.
    ready_force   = 1'b1;
    word_data_i   = 32'hDEADBEEF;
    word_strobe_i = 1'b1;
    add_word(32'hDEADBEEF);
    @(negedge clk);
    check("lat_t0_valid", 32'(in_valid_o), 32'd0);
    @(posedge clk); #1;
    word_strobe_i = 1'b0;
    @(negedge clk);
    check("lat_t1_valid", 32'(in_valid_o), 32'd0);
    check("lat_t1_busy", 32'(busy_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("lat_byte_valid", 32'(in_valid_o), 32'd1);
      check("lat_byte_data", 32'(in_data_o), 32'(db_bytes[i]));
    end
    @(negedge clk);
    check("lat_end_valid", 32'(in_valid_o), 32'd0);
    check("lat_end_busy", 32'(busy_o), 32'd0);
    @(posedge clk); #1;

    // Two back-to-back words: contiguous stream, checksum closes the frame.
    pulse_flush();
    word_data_i   = 32'h01020304;
    word_strobe_i = 1'b1;
    add_word(32'h01020304);
    @(posedge clk); #1;
    word_data_i = 32'h10203040;
    add_word(32'h10203040);
    @(posedge clk); #1;
    word_strobe_i = 1'b0;
    n_burst = 8;
`ifdef EFPGA_READBACK_CHECKSUM_EN
    n_burst = 9;
`endif
    for (int i = 0; i < n_burst; i++) begin
      @(negedge clk);
      check("burst_valid", 32'(in_valid_o), 32'd1);
    end
    @(negedge clk);
    check("burst_end_valid", 32'(in_valid_o), 32'd0);
    @(posedge clk); #1;

    // Random words and random ready.
    rand_mode = 1'b1;
    for (int r = 0; r < 6; r++) begin
      int n;
      n = (r == 0) ? 4 : $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        send_word($urandom);
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
      drain("rand");
    end
    rand_mode = 1'b0;

    // Overflow: ready low, 18 back-to-back strobes, the 18th is dropped.
    ready_force = 1'b0;
    pulse_flush();
    for (int i = 0; i < 18; i++) begin
      word_data_i   = $urandom;
      word_strobe_i = 1'b1;
      if (i < 17) add_word(word_data_i);
      if (i < 17) begin
        @(posedge clk); #1;
      end
    end
    @(negedge clk);
    check("ovf_before", 32'(overflow_o), 32'd0);
    @(posedge clk); #1;
    word_strobe_i = 1'b0;
    @(negedge clk);
    check("ovf_set", 32'(overflow_o), 32'd1);
    @(posedge clk); #1;
    b0 = n_bytes;
    ready_force = 1'b1;
    drain("ovf");
    exp_ovf_bytes = 68;
`ifdef EFPGA_READBACK_CHECKSUM_EN
    exp_ovf_bytes = 68 + 17 / int'(FrameWords);
`endif
    check("ovf_byte_count", 32'(n_bytes - b0), 32'(exp_ovf_bytes));
    check("ovf_sticky", 32'(overflow_o), 32'd1);

    // Flush while byte 1 of a word is pending.
    ready_force = 1'b0;
    send_word(32'h11223344);
    for (int c = 0; c < 20 && !in_valid_o; c++) begin
      @(posedge clk); #1;
    end
    check("flush_b0_valid", 32'(in_valid_o), 32'd1);
    ready_force = 1'b1;
    @(posedge clk); #1;
    ready_force = 1'b0;
    flush_i     = 1'b1;
    @(negedge clk);
    check("flush_b1_pending", 32'(in_data_o), 32'h22);
    @(posedge clk); #1;
    flush_i = 1'b0;
    @(negedge clk);
    check("flush_valid", 32'(in_valid_o), 32'd0);
    check("flush_overflow", 32'(overflow_o), 32'd0);
    check("flush_busy", 32'(busy_o), 32'd0);
    check("flush_data", 32'(in_data_o), 32'd0);
    @(posedge clk); #1;
    ready_force = 1'b1;
    send_word(32'hA5A5A5A5);
    send_word($urandom);
    drain("post_flush");

    // Reset while the last byte of a frame (checksum when built) is pending.
    send_word($urandom);
    send_word($urandom);
    for (int c = 0; c < 50 && exp_q.size() != 1; c++) begin
      @(posedge clk); #1;
    end
    check("rst_wait_last", 32'(exp_q.size()), 32'd1);
    ready_force = 1'b0;
    if (exp_q.size() != 0) check("rst_pending_byte", 32'(in_data_o), 32'(exp_q[0]));
    reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    @(negedge clk);
    check("rst2_data", 32'(in_data_o), 32'd0);
    check("rst2_valid", 32'(in_valid_o), 32'd0);
    check("rst2_overflow", 32'(overflow_o), 32'd0);
    check("rst2_busy", 32'(busy_o), 32'd0);
    @(posedge clk); #1;
    ready_force = 1'b1;
    send_word($urandom);
    send_word($urandom);
    drain("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
